p1_cmd_decoder: RTL and testbench

//  Protocol-1 downstream frame parser: splits each 512-byte USB frame from the ethernet RX byte

---
 rtl/p1_cmd_decoder.sv | 124 ++++++++++++
 tb/tb_p1_cmd_decoder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/p1_cmd_decoder.sv
// Protocol-1 downstream frame parser: splits each 512-byte frame into its C0..C4
// command word (presented on the cmd_* bus) and its payload byte stream.
module p1_cmd_decoder #(
   parameter logic [7:0] SYNC_BYTE     = 8'h7F,
   parameter int          PAYLOAD_BYTES = 504
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   input  logic        rx_sop,
   output logic [5:0]  cmd_addr,
   output logic [31:0] cmd_data,
   output logic        cmd_ptt,
   output logic        cmd_requires_resp,
   output logic        cmd_rqst,
   output logic [7:0]  pl_data,
   output logic        pl_valid,
   output logic        pl_last,
   output logic [7:0]  sync_err_cnt
);

   localparam int CNT_W = $clog2(PAYLOAD_BYTES);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PAYLOAD_BYTES - 1);

   typedef enum logic [3:0] {
      ST_HUNT, ST_S1, ST_S2, ST_C0, ST_C1, ST_C2, ST_C3, ST_C4, ST_PAYLOAD
   } state_t;

   state_t           state;
   logic [7:0]       c0_q, c1_q, c2_q, c3_q;
   logic [CNT_W-1:0] pl_cnt;
   logic             err_event;

   // A sop byte outside HUNT (truncation) and a bad sync0 on that same byte is one event.
   always_comb begin
      err_event = 1'b0;
      if (rx_valid) begin
         if (rx_sop)
            err_event = (state != ST_HUNT) || (rx_data != SYNC_BYTE);
         else if (state == ST_S1 || state == ST_S2)
            err_event = (rx_data != SYNC_BYTE);
      end
   end

   // NOTE: every register here, shadows included, is cleared by the synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state             <= ST_HUNT;
         c0_q              <= '0;
         c1_q              <= '0;
         c2_q              <= '0;
         c3_q              <= '0;
         pl_cnt            <= '0;
         cmd_addr          <= '0;
         cmd_data          <= '0;
         cmd_ptt           <= 1'b0;
         cmd_requires_resp <= 1'b0;
         cmd_rqst          <= 1'b0;
         pl_data           <= '0;
         pl_valid          <= 1'b0;
         pl_last           <= 1'b0;
         sync_err_cnt      <= '0;
      end else begin
         cmd_rqst <= 1'b0;
         pl_valid <= 1'b0;
         pl_last  <= 1'b0;

         if (err_event && sync_err_cnt != 8'hFF)
            sync_err_cnt <= sync_err_cnt + 8'd1;

         if (rx_valid) begin
            if (rx_sop) begin
               state <= (rx_data == SYNC_BYTE) ? ST_S1 : ST_HUNT;
            end else begin
               unique case (state)
                  ST_HUNT: state <= ST_HUNT;
                  ST_S1:   state <= (rx_data == SYNC_BYTE) ? ST_S2 : ST_HUNT;
                  ST_S2:   state <= (rx_data == SYNC_BYTE) ? ST_C0 : ST_HUNT;
                  ST_C0: begin
                     c0_q  <= rx_data;
                     state <= ST_C1;
                  end
                  ST_C1: begin
                     c1_q  <= rx_data;
                     state <= ST_C2;
                  end
                  ST_C2: begin
                     c2_q  <= rx_data;
                     state <= ST_C3;
                  end
                  ST_C3: begin
                     c3_q  <= rx_data;
                     state <= ST_C4;
                  end
                  ST_C4: begin
                     // C4 goes straight onto the bus; cmd_* only ever change here.
                     cmd_addr          <= c0_q[6:1];
                     cmd_ptt           <= c0_q[0];
                     cmd_requires_resp <= c0_q[7];
                     cmd_data          <= {c1_q, c2_q, c3_q, rx_data};
                     cmd_rqst          <= 1'b1;
                     pl_cnt            <= '0;
                     state             <= ST_PAYLOAD;
                  end
                  ST_PAYLOAD: begin
                     pl_data  <= rx_data;
                     pl_valid <= 1'b1;
                     if (pl_cnt == LAST_IDX) begin
                        pl_last <= 1'b1;
                        pl_cnt  <= '0;
                        state   <= ST_HUNT;
                     end else begin
                        pl_cnt <= pl_cnt + 1'b1;
                     end
                  end
                  default: state <= ST_HUNT;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_p1_cmd_decoder.sv
// Randomised bench for p1_cmd_decoder: a byte-position reference model predicts
// every output cycle by cycle, plus directed frame scenarios.
module tb_p1_cmd_decoder;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_sop;
   logic [5:0]  cmd_addr;
   logic [31:0] cmd_data;
   logic        cmd_ptt;
   logic        cmd_requires_resp;
   logic        cmd_rqst;
   logic [7:0]  pl_data;
   logic        pl_valid;
   logic        pl_last;
   logic [7:0]  sync_err_cnt;

   p1_cmd_decoder dut (
      .clk               (clk),
      .rst               (rst),
      .rx_data           (rx_data),
      .rx_valid          (rx_valid),
      .rx_sop            (rx_sop),
      .cmd_addr          (cmd_addr),
      .cmd_data          (cmd_data),
      .cmd_ptt           (cmd_ptt),
      .cmd_requires_resp (cmd_requires_resp),
      .cmd_rqst          (cmd_rqst),
      .pl_data           (pl_data),
      .pl_valid          (pl_valid),
      .pl_last           (pl_last),
      .sync_err_cnt      (sync_err_cnt)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   // Reference model: position within the frame (-1 = hunting for sop).
   int         m_pos;
   logic [7:0] m_hdr [0:7];
   int         exp_err;
   logic [5:0] exp_addr;
   logic [31:0] exp_data;
   logic       exp_ptt, exp_resp, exp_rqst, exp_plv, exp_pll;
   logic [7:0] exp_pld;

   // Observed event counters (from DUT) for scenario-level checks.
   int         seen_rqst, seen_plv, seen_pll;
   logic [7:0] last_pll_data;

   task automatic model_reset();
      m_pos = -1;
      exp_err = 0;
      exp_addr = '0; exp_data = '0; exp_ptt = 1'b0; exp_resp = 1'b0;
      exp_rqst = 1'b0; exp_plv = 1'b0; exp_pll = 1'b0; exp_pld = '0;
   endtask

   task automatic model_err();
      if (exp_err < 255) exp_err++;
   endtask

   task automatic model_accept(input logic v, input logic s, input logic [7:0] d);
      exp_rqst = 1'b0;
      exp_plv  = 1'b0;
      exp_pll  = 1'b0;
      if (!v) return;
      if (s) begin
         if (m_pos != -1 || d != 8'h7F) model_err();
         m_pos = (d == 8'h7F) ? 1 : -1;
      end else if (m_pos == -1) begin
         // idle between frames
      end else if (m_pos < 3) begin
         if (d != 8'h7F) begin
            model_err();
            m_pos = -1;
         end else m_pos++;
      end else if (m_pos < 8) begin
         m_hdr[m_pos] = d;
         if (m_pos == 7) begin
            exp_rqst = 1'b1;
            exp_addr = m_hdr[3][6:1];
            exp_ptt  = m_hdr[3][0];
            exp_resp = m_hdr[3][7];
            exp_data = {m_hdr[4], m_hdr[5], m_hdr[6], m_hdr[7]};
         end
         m_pos++;
      end else begin
         exp_plv = 1'b1;
         exp_pld = d;
         exp_pll = (m_pos == 511);
         m_pos   = (m_pos == 511) ? -1 : m_pos + 1;
      end
   endtask

   task automatic compare_all();
      check("cmd_rqst", 32'(cmd_rqst), 32'(exp_rqst));
      check("cmd_addr", 32'(cmd_addr), 32'(exp_addr));
      check("cmd_data", cmd_data, exp_data);
      check("cmd_ptt", 32'(cmd_ptt), 32'(exp_ptt));
      check("cmd_resp", 32'(cmd_requires_resp), 32'(exp_resp));
      check("pl_valid", 32'(pl_valid), 32'(exp_plv));
      check("pl_last", 32'(pl_last), 32'(exp_pll));
      if (exp_plv) check("pl_data", 32'(pl_data), 32'(exp_pld));
      check("sync_err_cnt", 32'(sync_err_cnt), 32'(exp_err));
      if (cmd_rqst) seen_rqst++;
      if (pl_valid) seen_plv++;
      if (pl_last) begin
         seen_pll++;
         last_pll_data = pl_data;
      end
   endtask

   task automatic step(input logic v, input logic s, input logic [7:0] d);
      rx_valid = v;
      rx_sop   = s;
      rx_data  = d;
      @(posedge clk);
      #1;
      model_accept(v, s, d);
      compare_all();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      rx_valid = 1'b0;
      rx_sop = 1'b0;
      rx_data = 8'h00;
      @(posedge clk);
      #1;
      model_reset();
      check("rst_cmd_rqst", 32'(cmd_rqst), 32'd0);
      check("rst_cmd_addr", 32'(cmd_addr), 32'd0);
      check("rst_cmd_data", cmd_data, 32'd0);
      check("rst_cmd_ptt", 32'(cmd_ptt), 32'd0);
      check("rst_cmd_resp", 32'(cmd_requires_resp), 32'd0);
      check("rst_pl_data", 32'(pl_data), 32'd0);
      check("rst_pl_valid", 32'(pl_valid), 32'd0);
      check("rst_pl_last", 32'(pl_last), 32'd0);
      check("rst_err_cnt", 32'(sync_err_cnt), 32'd0);
      rst = 1'b0;
   endtask

   task automatic idle(input int idle_pct);
      while (idle_pct > 0 && $urandom_range(99) < idle_pct)
         step(1'b0, 1'($urandom_range(1)), 8'($urandom));
   endtask

   // Sends the first nbytes of a frame; payload byte k carries k mod 256.
   task automatic send_frame(input logic [7:0] c0, c1, c2, c3, c4,
                             input logic [7:0] s1, input int nbytes, input int idle_pct);
      logic [7:0] b;
      for (int i = 0; i < nbytes; i++) begin
         idle(idle_pct);
         case (i)
            0, 2:    b = 8'h7F;
            1:       b = s1;
            3:       b = c0;
            4:       b = c1;
            5:       b = c2;
            6:       b = c3;
            7:       b = c4;
            default: b = 8'(i - 8);
         endcase
         step(1'b1, i == 0, b);
      end
   endtask

   int r0, p0, l0;

   initial begin
      seen_rqst = 0; seen_plv = 0; seen_pll = 0; last_pll_data = '0;
      model_reset();
      do_reset();
      do_reset();

      // 1: clean frame, continuous valid
      r0 = seen_rqst; p0 = seen_plv; l0 = seen_pll;
      send_frame(8'h13, 8'h12, 8'h34, 8'h56, 8'h78, 8'h7F, 512, 0);
      step(1'b0, 1'b0, 8'h00);
      check("t1_rqst_count", 32'(seen_rqst - r0), 32'd1);
      check("t1_pl_count", 32'(seen_plv - p0), 32'd504);
      check("t1_last_count", 32'(seen_pll - l0), 32'd1);
      check("t1_last_data", 32'(last_pll_data), 32'hF7);
      check("t1_addr", 32'(cmd_addr), 32'h09);
      check("t1_ptt", 32'(cmd_ptt), 32'd1);
      check("t1_resp", 32'(cmd_requires_resp), 32'd0);
      check("t1_data", cmd_data, 32'h12345678);
      check("t1_err", 32'(sync_err_cnt), 32'd0);

      // 2: same frame, C0=80, ~50% valid gaps
      r0 = seen_rqst; p0 = seen_plv;
      send_frame(8'h80, 8'h12, 8'h34, 8'h56, 8'h78, 8'h7F, 512, 50);
      step(1'b0, 1'b0, 8'h00);
      check("t2_rqst_count", 32'(seen_rqst - r0), 32'd1);
      check("t2_pl_count", 32'(seen_plv - p0), 32'd504);
      check("t2_addr", 32'(cmd_addr), 32'h00);
      check("t2_resp", 32'(cmd_requires_resp), 32'd1);
      check("t2_ptt", 32'(cmd_ptt), 32'd0);

      // 3: bad sync1 -> one error, nothing decoded, cmd held
      r0 = seen_rqst; p0 = seen_plv;
      send_frame(8'h05, 8'h01, 8'h02, 8'h03, 8'h04, 8'h7E, 512, 0);
      check("t3_err", 32'(sync_err_cnt), 32'd1);
      check("t3_rqst_count", 32'(seen_rqst - r0), 32'd0);
      check("t3_pl_count", 32'(seen_plv - p0), 32'd0);
      check("t3_data_held", cmd_data, 32'h12345678);
      send_frame(8'h0A, 8'h11, 8'h22, 8'h33, 8'h44, 8'h7F, 512, 10);
      check("t3_next_data", cmd_data, 32'h11223344);

      // 4: truncation by sop at payload byte 100
      do_reset();
      r0 = seen_rqst; p0 = seen_plv; l0 = seen_pll;
      send_frame(8'h13, 8'h12, 8'h34, 8'h56, 8'h78, 8'h7F, 108, 0);
      send_frame(8'h02, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h7F, 8, 0);
      step(1'b0, 1'b0, 8'h00);
      check("t4_err", 32'(sync_err_cnt), 32'd1);
      check("t4_pl_count", 32'(seen_plv - p0), 32'd100);
      check("t4_last_count", 32'(seen_pll - l0), 32'd0);
      check("t4_rqst_count", 32'(seen_rqst - r0), 32'd2);
      check("t4_data", cmd_data, 32'hAABBCCDD);
      send_frame(8'h02, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h7F, 512, 0);

      // 5: 300 bad sync0 bytes -> saturation
      for (int i = 0; i < 300; i++) step(1'b1, 1'b1, 8'h00);
      check("t5_sat", 32'(sync_err_cnt), 32'hFF);

      // 6: reset while waiting for C2, then a good frame
      r0 = seen_rqst;
      send_frame(8'h13, 8'h12, 8'h34, 8'h56, 8'h78, 8'h7F, 5, 0);
      do_reset();
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'h55);
      check("t6_no_rqst", 32'(seen_rqst - r0), 32'd0);
      send_frame(8'h13, 8'h12, 8'h34, 8'h56, 8'h78, 8'h7F, 512, 0);
      check("t6_data", cmd_data, 32'h12345678);

      // random frames with random truncation and sync corruption
      for (int f = 0; f < 24; f++) begin
         int n;
         logic [7:0] s1;
         n  = ($urandom_range(3) == 0) ? int'($urandom_range(511, 1)) : 512;
         s1 = ($urandom_range(5) == 0) ? 8'($urandom) : 8'h7F;
         send_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                    s1, n, int'($urandom_range(40)));
         if ($urandom_range(3) == 0) step(1'b1, 1'b0, 8'($urandom));
      end
      step(1'b0, 1'b0, 8'h00);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
